ysyx_22050078_ifu: RTL and testbench
====================================

Name: ysyx_22050078_ifu

Overview:
Instruction fetch unit, directly downstream of the PC register. It takes the current PC, issues one read on the instruction bus using an AXI-lite-style AR/R handshake, and selects the 32-bit instruction from the 64-bit beat. It holds the instruction with valid/ready toward decode. It pulses a PC write-enable to the PC unit only when decode accepts the instruction, so PC update stalls for multi-cycle memory.

Parameters:
CPU_WIDTH, 64, PC / address / bus data width
INST_WIDTH, 32, instruction width
RESET_PC, 64'h80000000, PC value driven on o_inst_pc at reset

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
i_pc  in  CPU_WIDTH  current PC from PC unit
i_flush  in  1  redirect; discard held/in-flight instruction
o_pc_wen  out  1  one-cycle pulse: PC unit may load next PC
o_arvalid  out  1  read request valid
o_araddr  out  CPU_WIDTH  request address = {pc[63:3],3'b0}
i_arready  in  1  request accepted
i_rvalid  in  1  read data valid
i_rdata  in  CPU_WIDTH  read data beat
i_rresp  in  2  0 = OKAY, nonzero = error
o_rready  out  1  read data accepted
o_inst_vld  out  1  instruction valid to decode
o_inst  out  INST_WIDTH  instruction
o_inst_pc  out  CPU_WIDTH  PC of o_inst
o_inst_err  out  1  fetch fault (misaligned or bus error); qualifies o_inst_vld
i_inst_rdy  in  1  decode accepts instruction

Behaviour:
- Reset is asynchronous and active-high. During reset: state IDLE, o_arvalid=0, o_rready=0, o_inst_vld=0, o_pc_wen=0, o_inst=0, o_inst_err=0, o_inst_pc=RESET_PC, o_araddr=0.
- FSM states: IDLE, REQ, WAIT, HOLD, DRAIN.
- IDLE: for one cycle after reset release, and after any hand-off or flush. In IDLE, latch pc_q <= i_pc.
  - If i_pc[1:0]!=0, go to HOLD with o_inst_err=1 and o_inst=0. No bus request is issued.
  - Otherwise go to REQ, with o_araddr <= {i_pc[63:3],3'b0}.
- REQ: o_arvalid=1. o_araddr stays stable until arready. On i_arready, go to WAIT.
  - i_flush in REQ: stay until i_arready, because a request cannot be withdrawn. Then go to DRAIN.
- WAIT: o_rready=1.
  - On i_rvalid: o_inst <= pc_q[2] ? rdata[63:32] : rdata[31:0]; o_inst_err <= (i_rresp!=0); o_inst_pc <= pc_q; go to HOLD.
  - i_flush in WAIT: go to DRAIN. If i_rvalid arrives in the same cycle, the beat is consumed and dropped, and the next state is IDLE.
- HOLD: o_inst_vld=1. o_inst, o_inst_pc and o_inst_err stay stable until accepted.
  - On i_inst_rdy: o_pc_wen=1 for exactly that cycle (combinational), then go to IDLE.
  - i_flush in HOLD: drop the instruction, no o_pc_wen, go to IDLE. If i_flush and i_inst_rdy are both high, flush wins.
- DRAIN: o_rready=1. Wait for i_rvalid, discard the data, go to IDLE. i_flush in DRAIN has no additional effect.
- Latency with zero-wait memory (arready and rvalid each high on their first cycle): IDLE→REQ→WAIT→HOLD. o_inst_vld asserts 3 cycles after IDLE. Throughput is 1 instruction per 4 cycles.
- At most one outstanding read at any time.
- The PC unit must load the next PC only on o_pc_wen. i_pc must be stable whenever the FSM is in IDLE.
- Reset asserted mid-transaction returns to IDLE immediately. The bus interconnect is reset by the same rst.

Decomposition:
- Shared defines: CPU_WIDTH, INST_WIDTH, RESET_PC, the FSM state encoding (3-bit localparams), and RESP_OKAY=2'b00.
- One natural sub-module: ysyx_22050078_inst_sel. It is combinational: 64-bit beat plus pc[2] → 32-bit instruction. It is reused later by the LSU for word extraction.
- State and data registers use the team's stdreg with the async-high reset variant.

Test Plan:
- Reset release, i_pc=0x80000000, memory with 0 wait states returns rdata=0x00000013_00100093 → o_araddr=0x80000000; o_inst=0x00100093, o_inst_pc=0x80000000, vld 3 cycles after IDLE; one o_pc_wen pulse when i_inst_rdy=1.
- i_pc=0x80000004, same beat → o_inst=0x00000013. Then hold i_inst_rdy=0 for 5 cycles → vld stays high, o_inst stable, no o_pc_wen until rdy.
- arready delayed 3 cycles, rvalid delayed 4 cycles → o_arvalid and o_araddr stable throughout the wait; exactly one AR and one R handshake.
- i_flush during WAIT, rvalid 2 cycles later with data 0xDEADBEEF → no o_inst_vld, no o_pc_wen; the next request uses the new i_pc.
- i_pc=0x80000002 → no o_arvalid; o_inst_vld=1 with o_inst_err=1 and o_inst_pc=0x80000002.
- i_rresp=2'b10 → o_inst_vld with o_inst_err=1. Separately, assert rst mid-REQ → all outputs at reset values in the same cycle.

Source files
------------

// File: rtl/ysyx_22050078_ifu_pkg.sv
// Shared constants and FSM encoding for the instruction fetch unit.
package ysyx_22050078_ifu_pkg;

  localparam int unsigned CPU_WIDTH  = 64;
  localparam int unsigned INST_WIDTH = 32;
  localparam logic [63:0] RESET_PC   = 64'h0000_0000_8000_0000;
  localparam logic [1:0]  RESP_OKAY  = 2'b00;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StReq   = 3'd1,
    StWait  = 3'd2,
    StHold  = 3'd3,
    StDrain = 3'd4
  } ifu_state_e;

endpackage

// File: rtl/ysyx_22050078_inst_sel.sv
// Selects one instruction-wide half of a bus beat; upper half when i_sel_hi is set.
module ysyx_22050078_inst_sel #(
  parameter int unsigned CPU_WIDTH  = ysyx_22050078_ifu_pkg::CPU_WIDTH,
  parameter int unsigned INST_WIDTH = ysyx_22050078_ifu_pkg::INST_WIDTH
) (
  input  logic [CPU_WIDTH-1:0]  i_beat,
  input  logic                  i_sel_hi,
  output logic [INST_WIDTH-1:0] o_inst
);

  // Half-select of the beat.
  always_comb begin
    o_inst = i_sel_hi ? i_beat[CPU_WIDTH-1 -: INST_WIDTH] : i_beat[INST_WIDTH-1:0];
  end

endmodule

// File: rtl/ysyx_22050078_ifu.sv
// Instruction fetch unit: one AR/R read per PC, holds the instruction toward decode and
// pulses o_pc_wen only when decode accepts it.
module ysyx_22050078_ifu #(
  parameter int unsigned          CPU_WIDTH  = ysyx_22050078_ifu_pkg::CPU_WIDTH,
  parameter int unsigned          INST_WIDTH = ysyx_22050078_ifu_pkg::INST_WIDTH,
  parameter logic [CPU_WIDTH-1:0] RESET_PC   = ysyx_22050078_ifu_pkg::RESET_PC
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CPU_WIDTH-1:0]  i_pc,
  input  logic                  i_flush,
  output logic                  o_pc_wen,
  output logic                  o_arvalid,
  output logic [CPU_WIDTH-1:0]  o_araddr,
  input  logic                  i_arready,
  input  logic                  i_rvalid,
  input  logic [CPU_WIDTH-1:0]  i_rdata,
  input  logic [1:0]            i_rresp,
  output logic                  o_rready,
  output logic                  o_inst_vld,
  output logic [INST_WIDTH-1:0] o_inst,
  output logic [CPU_WIDTH-1:0]  o_inst_pc,
  output logic                  o_inst_err,
  input  logic                  i_inst_rdy
);
  import ysyx_22050078_ifu_pkg::*;

  ifu_state_e              r_state, w_state_nxt;
  logic [CPU_WIDTH-1:0]    r_pc;
  logic [CPU_WIDTH-1:0]    r_araddr;
  logic [INST_WIDTH-1:0]   r_inst;
  logic [CPU_WIDTH-1:0]    r_inst_pc;
  logic                    r_inst_err;
  // Flush seen while the AR request was pending; the request cannot be withdrawn.
  logic                    r_flush_pend;
  logic [INST_WIDTH-1:0]   w_inst_sel;
  logic                    w_misalign;

  assign w_misalign = (i_pc[1:0] != 2'b00);

  ysyx_22050078_inst_sel #(
    .CPU_WIDTH  (CPU_WIDTH),
    .INST_WIDTH (INST_WIDTH)
  ) u_inst_sel (
    .i_beat   (i_rdata),
    .i_sel_hi (r_pc[2]),
    .o_inst   (w_inst_sel)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    o_arvalid   = 1'b0;
    o_rready    = 1'b0;
    o_inst_vld  = 1'b0;
    o_pc_wen    = 1'b0;
    case (r_state)
      StIdle: begin
        w_state_nxt = w_misalign ? StHold : StReq;
      end
      StReq: begin
        o_arvalid = 1'b1;
        if (i_arready) begin
          w_state_nxt = (i_flush || r_flush_pend) ? StDrain : StWait;
        end
      end
      StWait: begin
        o_rready = 1'b1;
        if (i_flush) begin
          // A beat arriving with the flush is consumed and dropped here.
          w_state_nxt = i_rvalid ? StIdle : StDrain;
        end else if (i_rvalid) begin
          w_state_nxt = StHold;
        end
      end
      StHold: begin
        o_inst_vld = 1'b1;
        o_pc_wen   = i_inst_rdy && !i_flush;
        if (i_flush || i_inst_rdy) begin
          w_state_nxt = StIdle;
        end
      end
      StDrain: begin
        o_rready = 1'b1;
        if (i_rvalid) begin
          w_state_nxt = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // Datapath registers: PC latch, request address and the held instruction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc         <= '0;
      r_araddr     <= '0;
      r_inst       <= '0;
      r_inst_pc    <= RESET_PC;
      r_inst_err   <= 1'b0;
      r_flush_pend <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          r_pc         <= i_pc;
          r_flush_pend <= 1'b0;
          if (w_misalign) begin
            r_inst     <= '0;
            r_inst_err <= 1'b1;
            r_inst_pc  <= i_pc;
          end else begin
            r_araddr <= {i_pc[CPU_WIDTH-1:3], 3'b000};
          end
        end
        StReq: begin
          if (i_flush) begin
            r_flush_pend <= 1'b1;
          end
        end
        StWait: begin
          if (i_rvalid && !i_flush) begin
            r_inst     <= w_inst_sel;
            r_inst_err <= (i_rresp != RESP_OKAY);
            r_inst_pc  <= r_pc;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_araddr   = r_araddr;
  assign o_inst     = r_inst;
  assign o_inst_pc  = r_inst_pc;
  assign o_inst_err = r_inst_err;

endmodule

// File: tb/tb_ysyx_22050078_ifu.sv
// Directed plus randomized bench for the fetch unit with a behavioural memory/decode model.
module tb_ysyx_22050078_ifu;

  localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;
  localparam logic [63:0] BEAT0  = 64'h0000_0013_0010_0093;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] i_pc;
  logic        i_flush;
  logic        o_pc_wen;
  logic        o_arvalid;
  logic [63:0] o_araddr;
  logic        i_arready;
  logic        i_rvalid;
  logic [63:0] i_rdata;
  logic [1:0]  i_rresp;
  logic        o_rready;
  logic        o_inst_vld;
  logic [31:0] o_inst;
  logic [63:0] o_inst_pc;
  logic        o_inst_err;
  logic        i_inst_rdy;

  int vectors     = 0;
  int miscompares = 0;
  int ar_hs       = 0;
  int r_hs        = 0;

  always #5 clk = ~clk;

  ysyx_22050078_ifu dut (
    .clk        (clk),
    .rst        (rst),
    .i_pc       (i_pc),
    .i_flush    (i_flush),
    .o_pc_wen   (o_pc_wen),
    .o_arvalid  (o_arvalid),
    .o_araddr   (o_araddr),
    .i_arready  (i_arready),
    .i_rvalid   (i_rvalid),
    .i_rdata    (i_rdata),
    .i_rresp    (i_rresp),
    .o_rready   (o_rready),
    .o_inst_vld (o_inst_vld),
    .o_inst     (o_inst),
    .o_inst_pc  (o_inst_pc),
    .o_inst_err (o_inst_err),
    .i_inst_rdy (i_inst_rdy)
  );

  // Bus handshake counters.
  always @(posedge clk) begin
    if (!rst) begin
      if (o_arvalid && i_arready) ar_hs++;
      if (o_rready && i_rvalid) r_hs++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Word at byte offset (pc mod 8) of a little-endian 64-bit beat.
  function automatic logic [31:0] ref_inst(input logic [63:0] pc, input logic [63:0] beat);
    logic [63:0] sh;
    sh = ((pc % 64'd8) >= 64'd4) ? (beat >> 32) : beat;
    return sh[31:0];
  endfunction

  // Aligned fetch starting at a negedge where the DUT is about to spend its IDLE cycle.
  task automatic fetch(input logic [63:0] pc, input int ar_dly, input int r_dly,
                       input logic [63:0] beat, input logic [1:0] resp, input int rdy_dly,
                       input bit kill);
    int          ar0;
    int          r0;
    logic [31:0] exp_inst;
    exp_inst = ref_inst(pc, beat);
    ar0  = ar_hs;
    r0   = r_hs;
    i_pc = pc;
    chk("idle_arvalid", {63'd0, o_arvalid}, 64'd0);
    step();
    for (int k = 0; k <= ar_dly; k++) begin
      chk("req_arvalid", {63'd0, o_arvalid}, 64'd1);
      chk("req_araddr", o_araddr, pc & 64'hFFFF_FFFF_FFFF_FFF8);
      i_arready = (k == ar_dly);
      step();
    end
    i_arready = 1'b0;
    for (int k = 0; k <= r_dly; k++) begin
      chk("wait_rready", {63'd0, o_rready}, 64'd1);
      chk("wait_arvalid", {63'd0, o_arvalid}, 64'd0);
      chk("wait_vld", {63'd0, o_inst_vld}, 64'd0);
      i_rvalid = (k == r_dly);
      i_rdata  = (k == r_dly) ? beat : {$urandom, $urandom};
      i_rresp  = resp;
      step();
    end
    i_rvalid = 1'b0;
    i_rresp  = 2'b00;
    chk("hold_vld", {63'd0, o_inst_vld}, 64'd1);
    chk("inst", {32'd0, o_inst}, {32'd0, exp_inst});
    chk("inst_pc", o_inst_pc, pc);
    chk("inst_err", {63'd0, o_inst_err}, {63'd0, resp != 2'b00});
    chk("ar_handshakes", 64'(ar_hs - ar0), 64'd1);
    chk("r_handshakes", 64'(r_hs - r0), 64'd1);
    for (int k = 0; k < rdy_dly; k++) begin
      step();
      chk("stall_vld", {63'd0, o_inst_vld}, 64'd1);
      chk("stall_inst", {32'd0, o_inst}, {32'd0, exp_inst});
      chk("stall_pc_wen", {63'd0, o_pc_wen}, 64'd0);
    end
    i_inst_rdy = 1'b1;
    i_flush    = kill;
    #1;
    chk("accept_pc_wen", {63'd0, o_pc_wen}, {63'd0, !kill});
    step();
    i_inst_rdy = 1'b0;
    i_flush    = 1'b0;
    chk("post_vld", {63'd0, o_inst_vld}, 64'd0);
    chk("post_pc_wen", {63'd0, o_pc_wen}, 64'd0);
  endtask

  // Misaligned PC: fault is presented without any bus request.
  task automatic fetch_misaligned(input logic [63:0] pc);
    int ar0;
    ar0  = ar_hs;
    i_pc = pc;
    step();
    chk("mis_vld", {63'd0, o_inst_vld}, 64'd1);
    chk("mis_err", {63'd0, o_inst_err}, 64'd1);
    chk("mis_inst", {32'd0, o_inst}, 64'd0);
    chk("mis_inst_pc", o_inst_pc, pc);
    chk("mis_arvalid", {63'd0, o_arvalid}, 64'd0);
    i_inst_rdy = 1'b1;
    #1;
    chk("mis_pc_wen", {63'd0, o_pc_wen}, 64'd1);
    step();
    i_inst_rdy = 1'b0;
    chk("mis_no_ar", 64'(ar_hs - ar0), 64'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_arvalid"}, {63'd0, o_arvalid}, 64'd0);
    chk({tag, "_rready"}, {63'd0, o_rready}, 64'd0);
    chk({tag, "_vld"}, {63'd0, o_inst_vld}, 64'd0);
    chk({tag, "_pc_wen"}, {63'd0, o_pc_wen}, 64'd0);
    chk({tag, "_inst"}, {32'd0, o_inst}, 64'd0);
    chk({tag, "_err"}, {63'd0, o_inst_err}, 64'd0);
    chk({tag, "_inst_pc"}, o_inst_pc, RST_PC);
    chk({tag, "_araddr"}, o_araddr, 64'd0);
  endtask

  initial begin
    logic [63:0] pc;
    logic [1:0]  resp;
    int          r0;
    rst        = 1'b1;
    i_pc       = RST_PC;
    i_flush    = 1'b0;
    i_arready  = 1'b0;
    i_rvalid   = 1'b0;
    i_rdata    = '0;
    i_rresp    = 2'b00;
    i_inst_rdy = 1'b0;
    step();
    step();
    chk_reset_outputs("reset");
    rst = 1'b0;

    // Zero-wait fetches, low and high word.
    fetch(64'h8000_0000, 0, 0, BEAT0, 2'b00, 0, 1'b0);
    fetch(64'h8000_0004, 0, 0, BEAT0, 2'b00, 5, 1'b0);
    // Slow memory.
    fetch(64'h8000_0008, 3, 4, 64'h1122_3344_5566_7788, 2'b00, 0, 1'b0);

    // Flush during WAIT, beat arrives two cycles later and is dropped.
    r0   = r_hs;
    i_pc = 64'h8000_0010;
    step();
    i_arready = 1'b1;
    step();
    i_arready = 1'b0;
    i_flush   = 1'b1;
    step();
    i_flush = 1'b0;
    chk("drain_rready", {63'd0, o_rready}, 64'd1);
    chk("drain_vld", {63'd0, o_inst_vld}, 64'd0);
    step();
    i_rvalid = 1'b1;
    i_rdata  = 64'h0000_0000_DEAD_BEEF;
    #1;
    chk("drain_pc_wen", {63'd0, o_pc_wen}, 64'd0);
    step();
    i_rvalid = 1'b0;
    chk("drain_done_vld", {63'd0, o_inst_vld}, 64'd0);
    chk("drain_done_rready", {63'd0, o_rready}, 64'd0);
    chk("drain_r_hs", 64'(r_hs - r0), 64'd1);
    fetch(64'h8000_0020, 0, 1, 64'hCAFE_F00D_0BAD_F00D, 2'b00, 0, 1'b0);

    // Flush while AR is pending: request completes, then drains.
    i_pc = 64'h8000_0030;
    step();
    i_flush = 1'b1;
    step();
    i_flush = 1'b0;
    chk("reqflush_arvalid", {63'd0, o_arvalid}, 64'd1);
    step();
    i_arready = 1'b1;
    step();
    i_arready = 1'b0;
    chk("reqflush_rready", {63'd0, o_rready}, 64'd1);
    chk("reqflush_vld", {63'd0, o_inst_vld}, 64'd0);
    i_rvalid = 1'b1;
    step();
    i_rvalid = 1'b0;
    chk("reqflush_idle_rready", {63'd0, o_rready}, 64'd0);
    chk("reqflush_idle_vld", {63'd0, o_inst_vld}, 64'd0);

    // Flush coinciding with the beat in WAIT goes straight back to IDLE.
    i_pc = 64'h8000_0040;
    step();
    i_arready = 1'b1;
    step();
    i_arready = 1'b0;
    i_flush   = 1'b1;
    i_rvalid  = 1'b1;
    step();
    i_flush  = 1'b0;
    i_rvalid = 1'b0;
    chk("wflush_rready", {63'd0, o_rready}, 64'd0);
    chk("wflush_vld", {63'd0, o_inst_vld}, 64'd0);

    // Flush wins over ready in HOLD; misaligned; bus error.
    fetch(64'h8000_0044, 1, 0, 64'h0123_4567_89AB_CDEF, 2'b00, 2, 1'b1);
    fetch_misaligned(64'h8000_0002);
    fetch(64'h8000_0048, 0, 2, 64'h5555_AAAA_3333_CCCC, 2'b10, 1, 1'b0);

    // Reset mid-REQ: outputs return to reset values without waiting for a clock.
    i_pc = 64'h8000_0050;
    step();
    chk("pre_rst_arvalid", {63'd0, o_arvalid}, 64'd1);
    rst = 1'b1;
    #1;
    chk_reset_outputs("midrst");
    step();
    rst = 1'b0;
    fetch(64'h8000_0054, 0, 0, 64'h7777_6666_5555_4444, 2'b00, 0, 1'b0);

    // Randomized fetches.
    for (int n = 0; n < 40; n++) begin
      pc = 64'h8000_0000 + (64'($urandom_range(0, 4095)) << 2);
      if ($urandom_range(0, 7) == 0) begin
        fetch_misaligned(pc | 64'($urandom_range(1, 3)));
      end else begin
        resp = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        fetch(pc, $urandom_range(0, 3), $urandom_range(0, 3), {$urandom, $urandom}, resp,
              $urandom_range(0, 3), ($urandom_range(0, 9) == 0));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
